// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters for the fetch stage.
// Lookup is combinational on the fetch PC; training and perf counters update on the rising edge.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc_f_i,
    output logic               predict_taken_o,
    output logic [31:0]        branch_target_o,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic               update_valid_i,
    input  logic [31:0]        update_pc_i,
    input  logic               update_taken_i,
    input  logic               update_is_jump_i,
    input  logic [31:0]        update_target_i,
    input  logic               update_pred_taken_i,
    output logic [COUNT_W-1:0] branch_count_o,
    output logic [COUNT_W-1:0] mispredict_count_o
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned IDX_LO  = 2;
    localparam int unsigned TAG_LO  = INDEX_BITS + 2;
    localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [ENTRIES-1:0]  jump_q;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic [1:0]            ctr_next;
    logic                  table_upd;
    logic                  count_upd;

    // PC bits outside the index/tag fields play no part in the lookup
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f_i[1:0], pc_f_i[31:TAG_HI+1],
                              update_pc_i[1:0], update_pc_i[31:TAG_HI+1]};

    assign f_idx = pc_f_i[TAG_LO-1:IDX_LO];
    assign f_tag = pc_f_i[TAG_HI:TAG_LO];
    assign u_idx = update_pc_i[TAG_LO-1:IDX_LO];
    assign u_tag = update_pc_i[TAG_HI:TAG_LO];

    // Fetch-side lookup; reset clears valid asynchronously so it falls back to pc+4
    always_comb begin
        f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predict_taken_o = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
        branch_target_o = predict_taken_o ? target_q[f_idx] : pc_f_i + 32'd4;
    end

    // Training-side hit detection and saturating counter step
    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        count_upd = en_i && update_valid_i;
        table_upd = count_upd && !flush_i;
        ctr_next  = ctr_q[u_idx];
        if (update_taken_i) begin
            if (ctr_q[u_idx] != 2'b11) ctr_next = ctr_q[u_idx] + 2'd1;
        end else begin
            if (ctr_q[u_idx] != 2'b00) ctr_next = ctr_q[u_idx] - 2'd1;
        end
    end

    // Table state: flush wins over a same-cycle update and only drops valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (en_i && flush_i) begin
            valid_q <= '0;
        end else if (table_upd) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_next;
                if (update_taken_i) begin
                    target_q[u_idx] <= update_target_i;
                    jump_q[u_idx]   <= update_is_jump_i;
                end
            end else if (update_taken_i) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= update_target_i;
                jump_q[u_idx]   <= update_is_jump_i;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

    // Saturating perf counters; they keep counting through a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else if (count_upd) begin
            if (branch_count_o != '1)
                branch_count_o <= branch_count_o + COUNT_W'(1);
            if ((update_pred_taken_i != update_taken_i) && (mispredict_count_o != '1))
                mispredict_count_o <= mispredict_count_o + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f_i;
    logic        predict_taken_o;
    logic [31:0] branch_target_o;
    logic        en_i;
    logic        flush_i;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        update_is_jump_i;
    logic [31:0] update_target_i;
    logic        update_pred_taken_i;
    logic [15:0] branch_count_o;
    logic [15:0] mispredict_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_f_i              (pc_f_i),
        .predict_taken_o     (predict_taken_o),
        .branch_target_o     (branch_target_o),
        .en_i                (en_i),
        .flush_i             (flush_i),
        .update_valid_i      (update_valid_i),
        .update_pc_i         (update_pc_i),
        .update_taken_i      (update_taken_i),
        .update_is_jump_i    (update_is_jump_i),
        .update_target_i     (update_target_i),
        .update_pred_taken_i (update_pred_taken_i),
        .branch_count_o      (branch_count_o),
        .mispredict_count_o  (mispredict_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic jump,
                           input logic [31:0] tgt, input logic pred);
        update_valid_i      = 1'b1;
        update_pc_i         = pc;
        update_taken_i      = taken;
        update_is_jump_i    = jump;
        update_target_i     = tgt;
        update_pred_taken_i = pred;
    endtask

    // One resolved branch presented for exactly one rising edge
    task automatic upd(input logic [31:0] pc, input logic taken, input logic jump,
                       input logic [31:0] tgt, input logic pred);
        @(negedge clk);
        set_upd(pc, taken, jump, tgt, pred);
        @(posedge clk);
        #1 update_valid_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_pred,
                        input logic [31:0] exp_tgt);
        pc_f_i = pc;
        #1;
        check({tag, "_pred"}, 32'(predict_taken_o), 32'(exp_pred));
        check({tag, "_tgt"}, branch_target_o, exp_tgt);
    endtask

    task automatic counts(input string tag, input int bc, input int mc);
        check({tag, "_bc"}, 32'(branch_count_o), 32'(bc));
        check({tag, "_mc"}, 32'(mispredict_count_o), 32'(mc));
    endtask

    initial begin
        rst_n = 1'b0;
        en_i = 1'b1;
        flush_i = 1'b0;
        pc_f_i = 32'h100;
        set_upd(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        update_valid_i = 1'b0;
        #12;
        look("rst", 32'h100, 1'b0, 32'h104);
        counts("rst", 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // First taken branch allocates weakly taken
        upd(32'h100, 1'b1, 1'b0, 32'h40, 1'b0);
        look("alloc", 32'h100, 1'b1, 32'h40);
        counts("alloc", 1, 1);

        // Decrement 10->01->00, then saturate at 00
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        look("nt1", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look("nt2", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b1, 1'b0, 32'h40, 1'b0);
        look("sat_lo", 32'h100, 1'b0, 32'h104);
        counts("sat_lo", 5, 3);

        // Increment 01->10->11, hold at 11, one not-taken leaves it taken
        upd(32'h100, 1'b1, 1'b0, 32'h40, 1'b1);
        look("inc", 32'h100, 1'b1, 32'h40);
        upd(32'h100, 1'b1, 1'b0, 32'h40, 1'b1);
        upd(32'h100, 1'b1, 1'b0, 32'h40, 1'b1);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        look("sat_hi", 32'h100, 1'b1, 32'h40);
        counts("sat_hi", 9, 4);

        // Alias 0x1100 shares index 0 with a different tag
        look("alias_miss", 32'h1100, 1'b0, 32'h1104);
        upd(32'h1100, 1'b1, 1'b0, 32'h200, 1'b1);
        look("alias_new", 32'h1100, 1'b1, 32'h200);
        look("alias_evict", 32'h100, 1'b0, 32'h104);
        upd(32'h140, 1'b0, 1'b0, 32'h0, 1'b0);
        look("miss_nt", 32'h1100, 1'b1, 32'h200);
        look("miss_nt2", 32'h140, 1'b0, 32'h144);
        counts("alias", 11, 4);

        // Jump stays taken regardless of the counter
        upd(32'h20, 1'b1, 1'b1, 32'h80, 1'b0);
        for (int i = 0; i < 4; i++) upd(32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
        look("jal", 32'h20, 1'b1, 32'h80);
        counts("jal", 16, 9);

        // Same-cycle lookup sees pre-update contents
        @(negedge clk);
        pc_f_i = 32'h30;
        set_upd(32'h30, 1'b1, 1'b0, 32'h300, 1'b0);
        #1;
        check("bypass_pre_pred", 32'(predict_taken_o), 32'h0);
        check("bypass_pre_tgt", branch_target_o, 32'h34);
        @(posedge clk);
        #1 update_valid_i = 1'b0;
        look("bypass_post", 32'h30, 1'b1, 32'h300);
        counts("bypass", 17, 10);

        // en_i low holds table and counters
        @(negedge clk);
        en_i = 1'b0;
        set_upd(32'h44, 1'b1, 1'b0, 32'h500, 1'b0);
        @(posedge clk);
        #1 update_valid_i = 1'b0;
        en_i = 1'b1;
        look("hold", 32'h44, 1'b0, 32'h48);
        counts("hold", 17, 10);

        // Flush beats a simultaneous update; counters still advance
        @(negedge clk);
        flush_i = 1'b1;
        set_upd(32'h44, 1'b1, 1'b0, 32'h500, 1'b1);
        @(posedge clk);
        #1 update_valid_i = 1'b0;
        flush_i = 1'b0;
        look("flush_a", 32'h30, 1'b0, 32'h34);
        look("flush_b", 32'h44, 1'b0, 32'h48);
        look("flush_c", 32'h20, 1'b0, 32'h24);
        look("flush_d", 32'h1100, 1'b0, 32'h1104);
        counts("flush", 18, 10);

        // Repopulate, then assert reset mid-cycle with an update in flight
        upd(32'h20, 1'b1, 1'b1, 32'h80, 1'b0);
        look("refill", 32'h20, 1'b1, 32'h80);
        @(negedge clk);
        set_upd(32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        counts("async_rst", 0, 0);
        look("async_rst", 32'h20, 1'b0, 32'h24);
        @(posedge clk);
        #1 update_valid_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        look("post_rst", 32'h20, 1'b0, 32'h24);
        counts("post_rst", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
